// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
// Imported by ifu_fifo and ifu_prefetch.
package ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              err;
    logic [31:0]       pc;
  } ifu_entry_t;

  function automatic int unsigned entry_w(input int unsigned addr_w);
    return INST_W + 1 + addr_w;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush and a registered head output.
// Head reads zero whenever the FIFO is empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_head;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_nxt;
  logic [AW:0]   w_cnt_nxt;
  logic [W-1:0]  w_head_nxt;

  assign w_full    = r_cnt == (AW+1)'(DEPTH);
  assign w_pop     = pop && (r_cnt != '0);
  assign w_push    = push && (!w_full || w_pop);
  assign w_rd_nxt  = r_rd + AW'(w_pop);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // Head is precomputed so the decode-side outputs come straight from flops.
  always_comb begin
    w_head_nxt = r_head;
    if (flush || w_cnt_nxt == '0) begin
      w_head_nxt = '0;
    end else if (r_cnt == (AW+1)'(w_pop)) begin
      w_head_nxt = din;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (flush) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        r_rd  <= w_rd_nxt;
        r_wr  <= r_wr + AW'(w_push);
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr] <= din;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && w_full && !pop && !flush));

  assign head  = r_head;
  assign empty = r_cnt == '0;
  assign count = r_cnt;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC, request FSM, drop tracking and prefetch FIFO.
// Define IFU_PERF_EN to add perf_fetch_cnt and perf_stall_cnt outputs.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       MAX_OUTST  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  input  logic              rsp_err,
  output logic              rsp_ready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = entry_w(ADDR_W);
  localparam logic [0:0]  S_IDLE = IDLE;
  localparam logic [0:0]  S_REQ  = REQ;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_rpc;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_drop;
  logic              r_stale;

  logic              w_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_empty;
  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_outst_nxt;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [EW-1:0]     w_head;

  assign w_acc       = (r_state == S_REQ) && req_ready;
  assign w_push      = rsp_valid && (r_drop == '0);
  assign w_pop       = inst_valid && inst_ready;
  assign w_outst_nxt = r_outst + CW'(w_acc) - CW'(rsp_valid);
  assign w_redir_pc  = redirect_pc & ~ADDR_W'(3);

  // Credit: a FIFO slot is reserved for every request still in flight.
  assign w_issue = !halt && !redirect_valid
                && (32'(r_outst) < 32'(MAX_OUTST))
                && ((32'(w_cnt) + 32'(r_outst)) < 32'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req_addr <= RESET_PC;
      r_fpc      <= RESET_PC;
      r_rpc      <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_stale    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_REQ;
            r_req_addr <= r_fpc;
          end
        end
        default: begin
          if (req_ready) r_state <= S_IDLE;
        end
      endcase
      r_outst <= w_outst_nxt;
      // A request held across a redirect is stale: drop its reply later.
      if (redirect_valid) begin
        r_fpc   <= w_redir_pc;
        r_rpc   <= w_redir_pc;
        r_drop  <= w_outst_nxt;
        r_stale <= (r_state == S_REQ) && !req_ready;
      end else begin
        if (w_acc && !r_stale) r_fpc <= r_fpc + ADDR_W'(4);
        if (w_push) r_rpc <= r_rpc + ADDR_W'(4);
        r_drop <= r_drop + CW'(w_acc && r_stale)
                         - CW'(rsp_valid && (r_drop != '0));
        if (w_acc) r_stale <= 1'b0;
      end
    end
  end

  ifu_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (w_push),
    .din   ({rsp_data, rsp_err, r_rpc}),
    .pop   (w_pop),
    .head  (w_head),
    .empty (w_empty),
    .count (w_cnt)
  );

  assign req_valid  = r_state == S_REQ;
  assign req_addr   = r_req_addr;
  assign rsp_ready  = 1'b1;
  assign inst_valid = !w_empty;
  assign inst       = w_head[EW-1 -: INST_W];
  assign inst_err   = w_head[ADDR_W];
  assign inst_pc    = w_head[ADDR_W-1:0];

`ifdef IFU_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (!inst_valid && !halt) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
